// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, imem port-A address, and a small {pc, inst} FIFO
// drained by decode. Optional misaligned-redirect halt is enabled by FETCH_MISALIGN_CHECK_EN.
module pc_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_wstrb,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_misalign
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, HALT} mode_e;

   mode_e                          mode_q, mode_d;
   logic [31:0]                    pc_q, pc_d;
   logic [PW-1:0]                  rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]                  count_q, count_d;
   logic [FIFO_DEPTH-1:0][31:0]    pc_mem_q, inst_mem_q;

   logic        pop, push;
   logic        redir_mis;
   logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_mis = |redirect_pc[1:0];
   assign redir_tgt = redirect_pc;
`else
   assign redir_mis = 1'b0;
   assign redir_tgt = redirect_pc & ~32'h0000_0003;
`endif

   assign pop  = out_valid & out_ready;
   assign push = (mode_q == RUN) & ~redirect_valid & ((count_q < CW'(FIFO_DEPTH)) | pop);

   always_comb begin
      mode_d  = mode_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (redirect_valid) begin
         // Redirect wins: any pop this cycle is discarded along with the whole FIFO.
         pc_d    = redir_tgt;
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
         mode_d  = redir_mis ? HALT : RUN;
      end else begin
         if (push) begin
            pc_d = pc_q + 32'd4;
            wr_d = wr_q + PW'(1);
         end
         if (pop) rd_d = rd_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= RUN;
         pc_q    <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         mode_q  <= mode_d;
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_q]   <= pc_q;
         inst_mem_q[wr_q] <= imem_rdata;
      end
   end

   assign imem_addr  = pc_q;
   assign imem_wstrb = 4'b0000;
   assign out_valid  = (count_q != '0) & (mode_q == RUN);
   assign out_inst   = out_valid ? inst_mem_q[rd_q] : NOP;
   assign out_pc     = out_valid ? pc_mem_q[rd_q] : 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign out_misalign = (mode_q == HALT);
`else
   assign out_misalign = 1'b0;
`endif

endmodule
